// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: FSM states, handshake levels
// and the ALU opcodes that route DIV/DIVU to it.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle. It works on operand
// magnitudes and applies the sign fix when the quotient is finalized.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  // Handshake: start_i stays high until ready_o is seen; ready_o and result_o
  // then hold while start_i stays high, and clear once start_i drops or annul_i rises.
  div_state_e state, next_state;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH:0]   work;
  logic [WIDTH-1:0]   divisor;
  logic               neg_quot;
  logic               neg_rem;

  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               accept;

  always_comb begin
    accept   = (start_i == DivStart) && !annul_i;
    mag_a    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    mag_b    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    trial    = work[2*WIDTH:WIDTH] - {1'b0, divisor};
    quot_fix = neg_quot ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    rem_fix  = neg_rem ? -work[2*WIDTH:WIDTH+1] : work[2*WIDTH:WIDTH+1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DivFree;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      DivFree: begin
        if (accept) next_state = (opdata2_i == '0) ? DivByZero : DivOn;
      end
      DivByZero: next_state = annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (annul_i)               next_state = DivFree;
        else if (cnt == CNT_LAST)  next_state = DivEnd;
      end
      DivEnd: begin
        if (start_i == DivStop || annul_i) next_state = DivFree;
      end
      default: next_state = DivFree;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          cnt      <= '0;
          // Operand signs are captured here so later input changes cannot leak in.
          if (accept) begin
            divisor  <= mag_b;
            work     <= {{WIDTH{1'b0}}, mag_a, 1'b0};
            neg_quot <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem  <= signed_div_i && opdata1_i[WIDTH-1];
          end
        end
        DivByZero: begin
          work <= '0;
          cnt  <= '0;
        end
        DivOn: begin
          if (annul_i) begin
            cnt <= '0;
          end else if (cnt != CNT_LAST) begin
            if (trial[WIDTH]) work <= {work[2*WIDTH-1:0], 1'b0};
            else              work <= {trial[WIDTH-1:0], work[WIDTH-1:0], 1'b1};
            cnt <= cnt + 1'b1;
          end else begin
            result_o <= {rem_fix, quot_fix};
            ready_o  <= DivResultReady;
            cnt      <= '0;
          end
        end
        DivEnd: begin
          if (start_i == DivStop || annul_i) begin
            ready_o  <= DivResultNotReady;
            result_o <= '0;
          end else begin
            ready_o <= DivResultReady;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a driver pushes the expected result and the
// expected ready cycle; a negedge monitor pops and checks on each ready_o rise.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  logic [63:0] exp_q[$];
  int          cyc_q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic        ready_prev = 1'b0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  always @(negedge clk) begin
    logic [63:0] e;
    int          c;
    if (ready_o && !ready_prev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ready: result=%h at cycle %0d, no request pending", result_o, cyc);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        if (result_o !== e) begin
          bad++;
          $display("FAIL result: got %h expected %h", result_o, e);
        end
        total++;
        if (cyc != c) begin
          bad++;
          $display("FAIL latency: ready at cycle %0d expected %0d", cyc, c);
        end
      end
    end
    ready_prev = ready_o;
  end

  // Caller is at a negedge; start is sampled on the following posedge.
  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input bit scramble, input bit hold);
    bit got;
    signed_div = sg; op1 = a; op2 = b; start = 1'b1;
    exp_q.push_back(exp);
    cyc_q.push_back(cyc + 1 + lat);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (scramble && i == 5) begin
        op1 = $urandom; op2 = $urandom_range(0, 255); signed_div = ~sg;
      end
      if (ready_o) begin got = 1; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL timeout: ready_o never rose for %h / %h", a, b);
    end
    if (!hold) begin
      start = 1'b0;
      @(negedge clk);
      total++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
        bad++;
        $display("FAIL drop: ready=%b result=%h expected ready=0 result=0", ready_o, result_o);
      end
    end
  endtask

  task automatic check_idle(input string name);
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL %s: ready=%b result=%h expected ready=0 result=0", name, ready_o, result_o);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    rst = 1'b0;
    @(negedge clk);

    do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0, 0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0, 0);
    do_div(1'b1, 32'h7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33, 0, 0);
    do_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'hE}, 33, 0, 0);
    do_div(1'b0, 32'h1234, 32'h0, 64'd0, 2, 0, 0);
    do_div(1'b1, 32'h1234, 32'h0, 64'd0, 2, 0, 0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 0, 0);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h1, {32'h0, 32'hFFFF_FFFF}, 33, 0, 0);
    do_div(1'b0, 32'd1000, 32'd7, {32'd6, 32'd142}, 33, 1, 0);

    // annul after 10 iterations
    signed_div = 1'b0; op1 = 32'hABC; op2 = 32'd3; start = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    check_idle("annul_free");
    annul = 1'b0; start = 1'b0;
    repeat (40) @(negedge clk);
    check_idle("annul_quiet");
    do_div(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, 0, 0);

    // start and annul together in FREE: nothing may start
    op1 = 32'd8; op2 = 32'd2; start = 1'b1; annul = 1'b1;
    repeat (40) @(negedge clk);
    check_idle("start_annul");
    start = 1'b0; annul = 1'b0;
    @(negedge clk);

    // hold in END, then async reset between edges
    do_div(1'b0, 32'd21, 32'd4, {32'd1, 32'd5}, 33, 0, 1);
    @(negedge clk);
    total++;
    if (ready_o !== 1'b1 || result_o !== {32'd1, 32'd5}) begin
      bad++;
      $display("FAIL end_hold: ready=%b result=%h expected ready=1 result=%h", ready_o, result_o, {32'd1, 32'd5});
    end
    #2 rst = 1'b1;
    #1 check_idle("async_reset_end");
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // async reset mid-ON, then full-latency operation
    signed_div = 1'b0; op1 = 32'h1000; op2 = 32'd3; start = 1'b1;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_idle("async_reset_on");
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0, 0);

    repeat (5) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
